// File: rtl/dec_latch_n.sv
// Registered N-to-M decoder with latch-enable hold, four output modes,
// change strobe, saturating update counter and out-of-range flag.
module dec_latch_n #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             le,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [OUT_W-1:0] out,
    output logic             oor,
    output logic             chg,
    output logic [CNT_W-1:0] upd_cnt
);

    typedef enum logic [1:0] {
        M_ONEHOT = 2'b00,
        M_THERM  = 2'b01,
        M_ONEHOT_N = 2'b10,
        M_STICKY = 2'b11
    } mode_e;

    logic [OUT_W-1:0] out_q, out_d;
    logic             oor_q, oor_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] dec;
    logic             sel_oor;

    // Out-of-range codes fall out naturally: no one-hot bit, all-ones thermometer.
    always_comb begin
        onehot = '0;
        therm  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (int'(sel) == i);
            therm[i]  = (i <= int'(sel));
        end
        sel_oor = (int'(sel) >= OUT_W);
    end

    always_comb begin
        dec = '0;
        case (mode_e'(mode))
            M_ONEHOT:   dec = onehot;
            M_THERM:    dec = therm;
            M_ONEHOT_N: dec = ~onehot;
            M_STICKY:   dec = out_q | onehot;
            default:    dec = onehot;
        endcase
    end

    always_comb begin
        out_d = out_q;
        oor_d = oor_q;
        unique case (1'b1)
            clr && le: begin
                // A clearing capture drops sticky history before the OR.
                out_d = (mode_e'(mode) == M_STICKY) ? onehot : dec;
                oor_d = sel_oor;
            end
            clr && !le: begin
                out_d = '0;
                oor_d = 1'b0;
            end
            !clr && le: begin
                out_d = dec;
                oor_d = sel_oor;
            end
            default: begin
                out_d = out_q;
                oor_d = oor_q;
            end
        endcase
    end

    always_comb begin
        chg_d = (out_d != out_q);
        cnt_d = cnt_q;
        if (chg_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_q <= '0;
            oor_q <= 1'b0;
            chg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            oor_q <= oor_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    assign out     = out_q;
    assign oor     = oor_q;
    assign chg     = chg_q;
    assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_dec_latch_n.sv
// Scoreboard bench for dec_latch_n: random and directed stimulus against
// an arithmetic reference model, plus an OUT_W=6 out-of-range instance.
module tb_dec_latch_n;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel = '0;
    logic       le = 1'b0;
    logic [1:0] mode = '0;
    logic       clr = 1'b0;
    logic [7:0] out;
    logic       oor, chg;
    logic [3:0] cnt;

    logic       rst6 = 1'b1;
    logic [2:0] sel6 = '0;
    logic       le6 = 1'b0;
    logic [1:0] mode6 = '0;
    logic       clr6 = 1'b0;
    logic [5:0] out6;
    logic       oor6, chg6;
    logic [3:0] cnt6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] o;
        logic       oor;
        logic       chg;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_out = '0;
    logic       m_oor = 1'b0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    dec_latch_n #(.SEL_W(3), .OUT_W(8), .CNT_W(4)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .sel(sel), .le(le), .mode(mode),
        .clr(clr), .out(out), .oor(oor), .chg(chg), .upd_cnt(cnt)
    );

    dec_latch_n #(.SEL_W(3), .OUT_W(6), .CNT_W(4)) u_dut6 (
        .sys_clk(clk), .sys_rst(rst6), .sel(sel6), .le(le6), .mode(mode6),
        .clr(clr6), .out(out6), .oor(oor6), .chg(chg6), .upd_cnt(cnt6)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: decode values built from plain shifts and masks.
    task automatic step(input int s, input bit l, input int m, input bit c);
        int oh, th, d, nxt;
        bit noor;
        exp_t e;
        sel  = 3'(s);
        le   = l;
        mode = 2'(m);
        clr  = c;
        oh = (s < W) ? (1 << s) : 0;
        th = (s >= W - 1) ? 255 : ((1 << (s + 1)) - 1);
        case (m)
            0: d = oh;
            1: d = th;
            2: d = (~oh) & 255;
            default: d = int'(m_out) | oh;
        endcase
        nxt  = int'(m_out);
        noor = m_oor;
        if (c && l) begin
            nxt  = (m == 3) ? oh : d;
            noor = (s >= W);
        end else if (c) begin
            nxt  = 0;
            noor = 1'b0;
        end else if (l) begin
            nxt  = d;
            noor = (s >= W);
        end
        e.chg = (8'(nxt) != m_out);
        if (e.chg && m_cnt < 15) m_cnt++;
        m_out = 8'(nxt);
        m_oor = noor;
        e.o   = m_out;
        e.oor = m_oor;
        e.cnt = 4'(m_cnt);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out", 32'(out), 32'(e.o));
                chk("oor", 32'(oor), 32'(e.oor));
                chk("chg", 32'(chg), 32'(e.chg));
                chk("upd_cnt", 32'(cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not end, limit %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int b;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_oor", 32'(oor), 32'h0);
        chk("rst_chg", 32'(chg), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        rst = 1'b0;

        repeat (5) step($urandom_range(0, 7), 0, $urandom_range(0, 3), 0);
        step(5, 1, 0, 0);
        step(5, 1, 0, 0);
        step(3, 1, 1, 0);
        step(0, 1, 2, 0);
        repeat (2) step($urandom_range(0, 7), 0, 0, 0);
        step(1, 1, 3, 0);
        step(4, 1, 3, 0);
        step(6, 1, 3, 0);
        step(2, 1, 3, 1);
        step($urandom_range(0, 7), 0, 3, 1);
        for (int i = 0; i < 20; i++) step((i % 2) ? 2 : 1, 1, 0, 0);

        // Counter is saturated now; reset the model/DUT to exercise it again.
        rst = 1'b1;
        m_out = '0;
        m_oor = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        b = 0;
        while (exp_q.size() > 0 && b < 10) begin
            @(negedge clk);
            b++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        step(5, 1, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out", 32'(out), 32'h0);
        chk("async_oor", 32'(oor), 32'h0);
        chk("async_chg", 32'(chg), 32'h0);
        chk("async_cnt", 32'(cnt), 32'h0);
        @(negedge clk);

        rst6 = 1'b0;
        sel6 = 3'd7; mode6 = 2'b00; le6 = 1'b1;
        @(posedge clk); #1;
        chk("w6_oh_out", 32'(out6), 32'h0);
        chk("w6_oh_oor", 32'(oor6), 32'h1);
        chk("w6_oh_chg", 32'(chg6), 32'h0);
        @(negedge clk);
        sel6 = 3'd3; mode6 = 2'b01;
        @(posedge clk); #1;
        chk("w6_th_out", 32'(out6), 32'h0f);
        chk("w6_th_oor", 32'(oor6), 32'h0);
        chk("w6_th_cnt", 32'(cnt6), 32'h1);
        @(negedge clk);
        sel6 = 3'd6; mode6 = 2'b01;
        @(posedge clk); #1;
        chk("w6_th_oor_out", 32'(out6), 32'h3f);
        chk("w6_th_oor_flag", 32'(oor6), 32'h1);
        @(negedge clk);
        sel6 = 3'd7; mode6 = 2'b11;
        @(posedge clk); #1;
        chk("w6_sticky_out", 32'(out6), 32'h3f);
        chk("w6_sticky_chg", 32'(chg6), 32'h0);
        @(negedge clk);
        le6 = 1'b0;
        #2;
        rst6 = 1'b1;
        #1;
        chk("w6_async_out", 32'(out6), 32'h0);
        chk("w6_async_oor", 32'(oor6), 32'h0);
        chk("w6_async_cnt", 32'(cnt6), 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
